// File: rtl/max_pri_arbiter_if.sv
// rtl/max_pri_arbiter_if.sv - request/grant bundle between requesters and the max-priority arbiter
interface max_pri_arbiter_if #(
    parameter int W = 4
);
    logic [3:0]     req;
    logic [4*W-1:0] pri;
    logic [3:0]     gnt;
    logic [1:0]     gnt_id;
    logic [W-1:0]   gnt_val;
    logic           tie;
    logic           busy;
    logic           tmo;

    modport master (
        output req, pri,
        input  gnt, gnt_id, gnt_val, tie, busy, tmo
    );

    modport slave (
        input  req, pri,
        output gnt, gnt_id, gnt_val, tie, busy, tmo
    );
endinterface

// File: rtl/max_pri_arbiter.sv
// rtl/max_pri_arbiter.sv - 4-lane max-priority arbiter, round-robin tie break, held grant
// Optional forced release after HOLD_MAX grant cycles when MAX_HOLD_EN is defined.
module max_pri_arbiter #(
    parameter int W        = 4,
    parameter int HOLD_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    max_pri_arbiter_if.slave     bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("HOLD_MAX out of range 1..255");
    end

    logic [0:0]   state_q,  state_d;
    logic [3:0]   gnt_q,    gnt_d;
    logic [1:0]   gnt_id_q, gnt_id_d;
    logic [W-1:0] gnt_val_q, gnt_val_d;
    logic         tie_q,    tie_d;
    logic [1:0]   rr_ptr_q, rr_ptr_d;

    logic [3:0]   elig;
    logic [3:0]   cand;
    logic [W-1:0] max_v;
    logic [2:0]   cand_cnt;
    logic [1:0]   win;
    logic         found;
    logic [1:0]   idx;

`ifdef MAX_HOLD_EN
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
    logic [7:0] hold_q, hold_d;
    logic [3:0] mask_q, mask_d;
    logic       tmo_q,  tmo_d;
    logic [3:0] masked;

    // A timed-out lane sits out one arbitration, but only if someone else wants the resource.
    always_comb begin
        masked = bus.req & ~mask_q;
        elig   = (masked != 4'd0) ? masked : bus.req;
    end
`else
    always_comb elig = bus.req;
`endif

    always_comb begin
        max_v    = '0;
        cand_cnt = 3'd0;
        win      = 2'd0;
        found    = 1'b0;
        idx      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (elig[i] && bus.pri[i*W +: W] > max_v)
                max_v = bus.pri[i*W +: W];
        end
        for (int i = 0; i < 4; i++) begin
            cand[i]  = elig[i] && (bus.pri[i*W +: W] == max_v);
            cand_cnt = cand_cnt + {2'd0, cand[i]};
        end
        // Scan candidates starting at the round-robin pointer.
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!found && cand[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_val_d = gnt_val_q;
        tie_d     = tie_q;
        rr_ptr_d  = rr_ptr_q;
`ifdef MAX_HOLD_EN
        hold_d    = hold_q;
        mask_d    = mask_q;
        tmo_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req != 4'd0) begin
                    state_d   = GRANT;
                    gnt_d     = 4'b0001 << win;
                    gnt_id_d  = win;
                    gnt_val_d = bus.pri[win*W +: W];
                    tie_d     = (cand_cnt > 3'd1);
                    rr_ptr_d  = win + 2'd1;
`ifdef MAX_HOLD_EN
                    hold_d    = 8'd0;
                    mask_d    = 4'd0;
`endif
                end
            end
            default: begin
                if (!bus.req[gnt_id_q]) begin
                    state_d = IDLE;
                    gnt_d   = 4'd0;
                    tie_d   = 1'b0;
                end
`ifdef MAX_HOLD_EN
                else if (hold_q == HOLD_LIM - 8'd1) begin
                    state_d = IDLE;
                    gnt_d   = 4'd0;
                    tie_d   = 1'b0;
                    tmo_d   = 1'b1;
                    mask_d  = gnt_q;
                end else begin
                    hold_d  = hold_q + 8'd1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 4'd0;
            gnt_id_q  <= 2'd0;
            gnt_val_q <= '0;
            tie_q     <= 1'b0;
            rr_ptr_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_val_q <= gnt_val_d;
            tie_q     <= tie_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

`ifdef MAX_HOLD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 8'd0;
            mask_q <= 4'd0;
            tmo_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            mask_q <= mask_d;
            tmo_q  <= tmo_d;
        end
    end
    assign bus.tmo = tmo_q;
`else
    assign bus.tmo = 1'b0;
`endif

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.gnt_val = gnt_val_q;
    assign bus.tie     = tie_q;
    assign bus.busy    = (state_q == GRANT);
endmodule

// File: tb/tb_max_pri_arbiter.sv
// tb/tb_max_pri_arbiter.sv - directed self-checking bench for max_pri_arbiter
module tb_max_pri_arbiter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_eval = 0;
    int   n_fail = 0;

    max_pri_arbiter_if #(.W(W)) arb_if ();

    max_pri_arbiter #(.W(W), .HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (arb_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_eval++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int g, input int id, input int v,
                             input int t, input int b);
        check({tag, ".gnt"},     int'(arb_if.gnt),     g);
        check({tag, ".gnt_id"},  int'(arb_if.gnt_id),  id);
        check({tag, ".gnt_val"}, int'(arb_if.gnt_val), v);
        check({tag, ".tie"},     int'(arb_if.tie),     t);
        check({tag, ".busy"},    int'(arb_if.busy),    b);
    endtask

    function automatic logic [15:0] pack(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    initial begin
        arb_if.req = 4'd0;
        arb_if.pri = '0;
        #2;
        check_out("reset", 0, 0, 0, 0, 0);
        check("reset.tmo", int'(arb_if.tmo), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        arb_if.req = 4'b1111;
        arb_if.pri = pack(3, 9, 5, 2);
        tick();
        check_out("first", 4'b0010, 1, 9, 0, 1);

        arb_if.pri = pack(3, 9, 5, 15);
        tick();
        check_out("nopreempt", 4'b0010, 1, 9, 0, 1);

        arb_if.req = 4'b1101;
        tick();
        check_out("release", 0, 1, 9, 0, 0);
        tick();
        check_out("b2b", 4'b1000, 3, 15, 0, 1);

        arb_if.req = 4'b0000;
        tick();
        check_out("rel_d", 0, 3, 15, 0, 0);

        arb_if.pri = pack(7, 7, 7, 7);
        for (int i = 0; i < 5; i++) begin
            arb_if.req = 4'b1111;
            tick();
            check_out($sformatf("tie%0d", i), 1 << (i % 4), i % 4, 7, 1, 1);
            arb_if.req = 4'b1111 & ~(4'b0001 << (i % 4));
            tick();
            check($sformatf("tie%0d_rel.gnt", i), int'(arb_if.gnt), 0);
        end

        arb_if.req = 4'b0000;
        tick();
        arb_if.req = 4'b0100;
        arb_if.pri = pack(9, 9, 0, 9);
        tick();
        check_out("c_zero", 4'b0100, 2, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0, 0, 0);
        arb_if.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        arb_if.req = 4'b0011;
        arb_if.pri = pack(8, 1, 0, 0);
        tick();
        check_out("hold_a", 4'b0001, 0, 8, 0, 1);
`ifdef MAX_HOLD_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d.gnt", i), int'(arb_if.gnt), 4'b0001);
            check($sformatf("hold%0d.tmo", i), int'(arb_if.tmo), 0);
        end
        tick();
        check("tmo.gnt",  int'(arb_if.gnt),  0);
        check("tmo.tmo",  int'(arb_if.tmo),  1);
        check("tmo.busy", int'(arb_if.busy), 0);
        tick();
        check_out("after_tmo", 4'b0010, 1, 1, 0, 1);
        check("after_tmo.tmo", int'(arb_if.tmo), 0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            check($sformatf("hold%0d.gnt", i), int'(arb_if.gnt), 4'b0001);
            check($sformatf("hold%0d.tmo", i), int'(arb_if.tmo), 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end
endmodule

// File: doc/max_pri_arbiter.md
Name: max_pri_arbiter

Overview:
- Sequential arbiter that shares one resource among 4 requesters.
- Each requester presents a 4-bit priority value. The highest-valued active requester wins.
- Ties between equal maximum values are broken round-robin.
- Winner is registered and its grant held until the requester releases. This is the control front-end for the 4-input magnitude-compare datapath in the comparator family.

Parameters:
- W, 4, width of each priority value.
- HOLD_MAX, 15, maximum grant-hold cycles; used only when MAX_HOLD_EN is defined; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines; bit0=a, bit1=b, bit2=c, bit3=d.
- pri  input  4*W  packed priorities; pri[W-1:0]=a ... pri[4W-1:3W]=d.
- gnt  output  4  one-hot grant, registered.
- gnt_id  output  2  index of granted lane, registered.
- gnt_val  output  W  priority of granted lane, captured at arbitration.
- tie  output  1  registered; set when the winning value was shared by more than one eligible lane.
- busy  output  1  high in GRANT state.
- tmo  output  1  one-cycle pulse on forced release (MAX_HOLD_EN only; else constant 0).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, gnt_id=0, gnt_val=0, tie=0, busy=0, tmo=0, rr_ptr=0, hold counter=0. Takes effect immediately, including mid-grant.
- Eligible lane: req[i]=1. Priority of non-requesting lanes is ignored. Priority 0 is eligible.
- Winner selection (combinational, evaluated in IDLE only):
  - Find max = highest pri among eligible lanes, unsigned compare.
  - Candidates = eligible lanes with pri==max.
  - Winner = first candidate scanning rr_ptr, rr_ptr+1, ... mod 4.
- FSM, 2 states:
  - IDLE: if req==0, stay; outputs 0.
  - IDLE: if req!=0, at next edge go to GRANT. Load gnt=onehot(winner), gnt_id=winner, gnt_val=pri[winner], tie=(candidate count>1), busy=1. Set rr_ptr=winner+1 mod 4 (wraps 3->0).
  - GRANT: hold all registered outputs stable while req[gnt_id]=1. Changes on other req/pri lines are ignored, with no preemption, even by a higher value.
  - GRANT: when req[gnt_id]=0 at an edge, go to IDLE. gnt, busy and tie clear; gnt_id and gnt_val keep their last value.
- Latency:
  - Request sampled at edge N gives gnt at edge N+1.
  - Release sampled at edge M clears gnt at M+1.
  - Minimum one IDLE cycle between grants, so a back-to-back grant appears at M+2.
- gnt is always one-hot or zero, never multi-hot.
- Simultaneous release of the granted lane and assertion of a new request: the new request is arbitrated on the following IDLE cycle.
- Requests dropped while in IDLE before an edge are simply not seen.

Optional Feature:
- Macro: MAX_HOLD_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the count reaches HOLD_MAX while req[gnt_id] is still 1: go to IDLE, clear gnt, and pulse tmo=1 for that cycle.
  - The timed-out lane is masked from eligibility in the next arbitration only if another lane is requesting; otherwise it may win again.
- Not defined:
  - No counter is present and tmo is tied 0.
  - A grant is held indefinitely until release.

Test Plan:
- Reset then req=4'b1111, pri a=3 b=9 c=5 d=2 -> next cycle gnt=4'b0010, gnt_id=1, gnt_val=9, tie=0, busy=1, rr_ptr=2.
- While b is granted, set pri d=15 -> gnt unchanged. Drop req[1] -> gnt=0 next edge; following edge gnt=4'b1000, gnt_val=15.
- Tie: all four request with pri=7, rr_ptr=0 -> grants in order a,b,c,d across four release cycles, tie=1 each time. Fifth grant returns to a (wrap).
- Only c requesting with pri=0 -> gnt=4'b0100, gnt_val=0. Assert rst_n=0 mid-grant -> gnt=0 and busy=0 asynchronously, before the next clk edge.
- MAX_HOLD_EN, HOLD_MAX=4: a holds req with pri=8 while b requests with pri=1 -> after 4 GRANT cycles tmo pulses, gnt=0; next grant goes to b.
- Without MAX_HOLD_EN, same stimulus for 100 cycles -> a stays granted and tmo stays 0.
